sram_axi_bridge: RTL and testbench

Bridges the CPU core's two sram-like request ports (instruction fetch, data load/store) onto a single AXI3 master port. It sits directly below `mycpu_top` and is the only path from the core to memory. Data requests win arbitration over instruction requests. Exactly one AXI transaction is outstanding at a time, always single-beat.

---
 rtl/sram_axi_bridge_pkg.sv | 37 +++
 rtl/sram_axi_bridge_if.sv | 73 +++++++
 rtl/sram_axi_bridge_wstrb_gen.sv | 21 ++
 rtl/sram_axi_bridge.sv | 201 ++++++++++++++++++++
 tb/tb_sram_axi_bridge.sv | 492 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_axi_bridge_pkg.sv
// Shared types and constants for the sram-to-AXI3 bridge.
// State encodings, default IDs, size codes and the latched request bundle.
package sram_axi_bridge_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR_ADDR = 3'd3,
    S_WR_RESP = 3'd4
  } state_e;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  localparam logic [3:0] ID_INST_DEF = 4'd0;
  localparam logic [3:0] ID_DATA_DEF = 4'd1;

  localparam logic [1:0] SizeByte = 2'd0;
  localparam logic [1:0] SizeHalf = 2'd1;
  localparam logic [1:0] SizeWord = 2'd2;

  typedef struct packed {
    owner_e      owner;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  function automatic logic [2:0] axi_size(input logic [1:0] s);
    return {1'b0, s};
  endfunction

endpackage

// File: rtl/sram_axi_bridge_if.sv
// AXI3 master bus between the bridge and memory.
// Single-beat only; tie-off fields are carried for completeness.
interface sram_axi_bridge_if;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;

  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst,
    output arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst,
    output awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst,
    input  arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst,
    input  awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bvalid,
    input  bready
  );

endinterface

// File: rtl/sram_axi_bridge_wstrb_gen.sv
// Byte-lane strobe from access size and low address bits.
// Store data is already lane-aligned, so only the strobe moves.
module wstrb_gen
  import sram_axi_bridge_pkg::*;
(
  input  logic [1:0] i_size,
  input  logic [1:0] i_addr,
  output logic [3:0] o_wstrb
);

  // size/offset decode; unknown size codes fall back to a full word
  always_comb begin
    o_wstrb = 4'b1111;
    unique case (1'b1)
      (i_size == SizeByte): o_wstrb = 4'b0001 << i_addr;
      (i_size == SizeHalf): o_wstrb = i_addr[1] ? 4'b1100 : 4'b0011;
      default:              o_wstrb = 4'b1111;
    endcase
  end

endmodule

// File: rtl/sram_axi_bridge.sv
// Arbitrates the inst and data sram-like ports onto one AXI3 master.
// One single-beat transaction in flight; data beats inst on a tie.
module sram_axi_bridge
  import sram_axi_bridge_pkg::*;
#(
  parameter logic [3:0] ID_INST = ID_INST_DEF,
  parameter logic [3:0] ID_DATA = ID_DATA_DEF
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  sram_axi_bridge_if.master axi
);

  state_e      r_state;
  req_t        r_req;
  logic        r_arvalid;
  logic        r_rready;
  logic        r_awvalid;
  logic        r_wvalid;
  logic        r_bready;
  logic        r_aw_done;
  logic        r_w_done;
  logic        r_inst_ok;
  logic        r_data_ok;
  logic [31:0] r_inst_rdata;
  logic [31:0] r_data_rdata;

  logic        w_idle;
  logic        w_grant;
  req_t        w_new;
  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_aw_all;
  logic        w_w_all;
  logic [3:0]  w_wstrb;
  logic        w_unused;

  assign w_idle       = (r_state == S_IDLE);
  assign data_addr_ok = w_idle & data_req;
  assign inst_addr_ok = w_idle & inst_req & ~data_req;
  assign w_grant      = w_idle & (data_req | inst_req);

  assign w_aw_hs  = r_awvalid & axi.awready;
  assign w_w_hs   = r_wvalid & axi.wready;
  assign w_aw_all = r_aw_done | w_aw_hs;
  assign w_w_all  = r_w_done | w_w_hs;

  // request to latch on grant; an inst fetch is always a word read
  always_comb begin
    w_new       = '0;
    w_new.wdata = data_wdata;
    if (data_req) begin
      w_new.owner = OWN_DATA;
      w_new.wr    = data_wr;
      w_new.size  = data_size;
      w_new.addr  = data_addr;
    end else begin
      w_new.owner = OWN_INST;
      w_new.wr    = 1'b0;
      w_new.size  = SizeWord;
      w_new.addr  = inst_addr;
    end
  end

  // transaction FSM with registered handshake and completion outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_req        <= '0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_bready     <= 1'b0;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
      r_inst_ok    <= 1'b0;
      r_data_ok    <= 1'b0;
      r_inst_rdata <= '0;
      r_data_rdata <= '0;
    end else begin
      r_inst_ok <= 1'b0;
      r_data_ok <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_req <= w_new;
            if (w_new.wr) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= S_WR_ADDR;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= S_RD_ADDR;
            end
          end
        end
        S_RD_ADDR: begin
          if (axi.arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (axi.rvalid) begin
            r_rready <= 1'b0;
            r_state  <= S_IDLE;
            if (r_req.owner == OWN_DATA) begin
              r_data_rdata <= axi.rdata;
              r_data_ok    <= 1'b1;
            end else begin
              r_inst_rdata <= axi.rdata;
              r_inst_ok    <= 1'b1;
            end
          end
        end
        S_WR_ADDR: begin
          if (w_aw_hs) r_awvalid <= 1'b0;
          if (w_w_hs)  r_wvalid  <= 1'b0;
          if (w_aw_all && w_w_all) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_bready  <= 1'b1;
            r_state   <= S_WR_RESP;
          end else begin
            r_aw_done <= w_aw_all;
            r_w_done  <= w_w_all;
          end
        end
        S_WR_RESP: begin
          if (axi.bvalid) begin
            r_bready  <= 1'b0;
            r_data_ok <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  wstrb_gen u_wstrb (
    .i_size  (r_req.size),
    .i_addr  (r_req.addr[1:0]),
    .o_wstrb (w_wstrb)
  );

  assign inst_data_ok = r_inst_ok;
  assign inst_rdata   = r_inst_rdata;
  assign data_data_ok = r_data_ok;
  assign data_rdata   = r_data_rdata;

  assign axi.arid    = (r_req.owner == OWN_DATA) ? ID_DATA : ID_INST;
  assign axi.araddr  = r_req.addr;
  assign axi.arlen   = 4'd0;
  assign axi.arsize  = axi_size(r_req.size);
  assign axi.arburst = 2'b01;
  assign axi.arlock  = 2'b00;
  assign axi.arcache = 4'd0;
  assign axi.arprot  = 3'd0;
  assign axi.arvalid = r_arvalid;
  assign axi.rready  = r_rready;

  assign axi.awid    = ID_DATA;
  assign axi.awaddr  = r_req.addr;
  assign axi.awlen   = 4'd0;
  assign axi.awsize  = axi_size(r_req.size);
  assign axi.awburst = 2'b01;
  assign axi.awlock  = 2'b00;
  assign axi.awcache = 4'd0;
  assign axi.awprot  = 3'd0;
  assign axi.awvalid = r_awvalid;

  assign axi.wid    = ID_DATA;
  assign axi.wdata  = r_req.wdata;
  assign axi.wstrb  = w_wstrb;
  assign axi.wlast  = 1'b1;
  assign axi.wvalid = r_wvalid;
  assign axi.bready = r_bready;

  // rid/rlast carry nothing for single-beat, in-order traffic
  assign w_unused = &{1'b0, axi.rid, axi.rlast, r_req.wr};

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge.
// Each task drives one scenario and checks its own expectations.
module tb_sram_axi_bridge;

  logic        clk;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  int n_vec;
  int n_err;

  sram_axi_bridge_if axi ();

  sram_axi_bridge dut (
    .clk          (clk),
    .rst          (rst),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .axi          (axi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    #1;
    n_vec++;
    if ({axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_vr got %b want 00000",
        {axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready});
    end
    n_vec++;
    if ({inst_data_ok, data_data_ok} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_ok got %b want 00", {inst_data_ok, data_data_ok});
    end
    n_vec++;
    if ({inst_rdata, data_rdata} !== 64'h0) begin
      n_err++;
      $display("FAIL reset_rdata got %h want 0", {inst_rdata, data_rdata});
    end
    n_vec++;
    if ({axi.araddr, axi.awaddr, axi.arsize, axi.awsize} !== 70'h0) begin
      n_err++;
      $display("FAIL reset_addr got %h want 0",
        {axi.araddr, axi.awaddr, axi.arsize, axi.awsize});
    end
    rst = 1'b0;
  endtask

  task automatic test_inst_read();
    tick();
    inst_req = 1'b1;
    inst_addr = 32'hBFC00000;
    axi.arready = 1'b1;
    axi.rvalid = 1'b1;
    axi.rdata = 32'h3C1D0001;
    #1;
    n_vec++;
    if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin
      n_err++;
      $display("FAIL ir_addr_ok got %b want 10", {inst_addr_ok, data_addr_ok});
    end
    tick();
    inst_req = 1'b0;
    #1;
    n_vec++;
    if ({axi.arvalid, axi.araddr, axi.arid, axi.arsize} !== {1'b1, 32'hBFC00000, 4'd0, 3'd2}) begin
      n_err++;
      $display("FAIL ir_ar got %h want %h",
        {axi.arvalid, axi.araddr, axi.arid, axi.arsize}, {1'b1, 32'hBFC00000, 4'd0, 3'd2});
    end
    n_vec++;
    if ({axi.arlen, axi.arburst, axi.arlock, axi.arcache, axi.arprot} !== 15'b0000_01_00_0000_000) begin
      n_err++;
      $display("FAIL ir_tieoff got %b want 000001000000000",
        {axi.arlen, axi.arburst, axi.arlock, axi.arcache, axi.arprot});
    end
    tick();
    #1;
    n_vec++;
    if ({axi.arvalid, axi.rready, inst_data_ok} !== 3'b010) begin
      n_err++;
      $display("FAIL ir_c2 got %b want 010", {axi.arvalid, axi.rready, inst_data_ok});
    end
    tick();
    #1;
    n_vec++;
    if ({inst_data_ok, inst_rdata} !== {1'b1, 32'h3C1D0001}) begin
      n_err++;
      $display("FAIL ir_data got %h want %h", {inst_data_ok, inst_rdata}, {1'b1, 32'h3C1D0001});
    end
    tick();
    axi.arready = 1'b0;
    axi.rvalid = 1'b0;
    #1;
    n_vec++;
    if ({inst_data_ok, inst_rdata} !== {1'b0, 32'h3C1D0001}) begin
      n_err++;
      $display("FAIL ir_hold got %h want %h", {inst_data_ok, inst_rdata}, {1'b0, 32'h3C1D0001});
    end
  endtask

  task automatic test_arbitration();
    tick();
    inst_req = 1'b1;
    inst_addr = 32'hBFC00004;
    data_req = 1'b1;
    data_wr = 1'b0;
    data_size = 2'd2;
    data_addr = 32'h80001004;
    axi.arready = 1'b1;
    axi.rvalid = 1'b1;
    axi.rdata = 32'h11112222;
    #1;
    n_vec++;
    if ({data_addr_ok, inst_addr_ok} !== 2'b10) begin
      n_err++;
      $display("FAIL arb_grant got %b want 10", {data_addr_ok, inst_addr_ok});
    end
    tick();
    data_req = 1'b0;
    #1;
    n_vec++;
    if ({inst_addr_ok, axi.arid, axi.araddr} !== {1'b0, 4'd1, 32'h80001004}) begin
      n_err++;
      $display("FAIL arb_data_ar got %h want %h",
        {inst_addr_ok, axi.arid, axi.araddr}, {1'b0, 4'd1, 32'h80001004});
    end
    tick();
    #1;
    tick();
    axi.rdata = 32'h33334444;
    #1;
    n_vec++;
    if ({data_data_ok, data_rdata, inst_addr_ok} !== {1'b1, 32'h11112222, 1'b1}) begin
      n_err++;
      $display("FAIL arb_data_done got %h want %h",
        {data_data_ok, data_rdata, inst_addr_ok}, {1'b1, 32'h11112222, 1'b1});
    end
    tick();
    inst_req = 1'b0;
    #1;
    n_vec++;
    if ({axi.arvalid, axi.arid, axi.araddr} !== {1'b1, 4'd0, 32'hBFC00004}) begin
      n_err++;
      $display("FAIL arb_inst_ar got %h want %h",
        {axi.arvalid, axi.arid, axi.araddr}, {1'b1, 4'd0, 32'hBFC00004});
    end
    tick();
    #1;
    tick();
    #1;
    n_vec++;
    if ({inst_data_ok, inst_rdata, data_rdata} !== {1'b1, 32'h33334444, 32'h11112222}) begin
      n_err++;
      $display("FAIL arb_inst_done got %h want %h",
        {inst_data_ok, inst_rdata, data_rdata}, {1'b1, 32'h33334444, 32'h11112222});
    end
    tick();
    axi.arready = 1'b0;
    axi.rvalid = 1'b0;
    #1;
  endtask

  task automatic test_narrow_store();
    tick();
    data_req = 1'b1;
    data_wr = 1'b1;
    data_size = 2'd0;
    data_addr = 32'h80000003;
    data_wdata = 32'hAB000000;
    axi.awready = 1'b1;
    axi.wready = 1'b1;
    axi.bvalid = 1'b1;
    #1;
    n_vec++;
    if (data_addr_ok !== 1'b1) begin
      n_err++;
      $display("FAIL sb_addr_ok got %b want 1", data_addr_ok);
    end
    tick();
    data_req = 1'b0;
    #1;
    n_vec++;
    if ({axi.awvalid, axi.wvalid, axi.awsize, axi.wstrb, axi.wlast} !== {2'b11, 3'd0, 4'b1000, 1'b1}) begin
      n_err++;
      $display("FAIL sb_aw_w got %b want %b",
        {axi.awvalid, axi.wvalid, axi.awsize, axi.wstrb, axi.wlast}, {2'b11, 3'd0, 4'b1000, 1'b1});
    end
    n_vec++;
    if ({axi.awaddr, axi.wdata, axi.awid, axi.wid} !== {32'h80000003, 32'hAB000000, 4'd1, 4'd1}) begin
      n_err++;
      $display("FAIL sb_fields got %h want %h",
        {axi.awaddr, axi.wdata, axi.awid, axi.wid}, {32'h80000003, 32'hAB000000, 4'd1, 4'd1});
    end
    tick();
    #1;
    n_vec++;
    if ({axi.awvalid, axi.wvalid, axi.bready, data_data_ok} !== 4'b0010) begin
      n_err++;
      $display("FAIL sb_resp got %b want 0010",
        {axi.awvalid, axi.wvalid, axi.bready, data_data_ok});
    end
    tick();
    #1;
    n_vec++;
    if ({data_data_ok, axi.bready} !== 2'b10) begin
      n_err++;
      $display("FAIL sb_done got %b want 10", {data_data_ok, axi.bready});
    end
    tick();
    data_req = 1'b1;
    data_size = 2'd1;
    data_addr = 32'h80000002;
    data_wdata = 32'hCDEF0000;
    #1;
    n_vec++;
    if ({data_data_ok, data_addr_ok} !== 2'b01) begin
      n_err++;
      $display("FAIL sh_grant got %b want 01", {data_data_ok, data_addr_ok});
    end
    tick();
    data_req = 1'b0;
    #1;
    n_vec++;
    if ({axi.awsize, axi.wstrb, axi.wdata} !== {3'd1, 4'b1100, 32'hCDEF0000}) begin
      n_err++;
      $display("FAIL sh_strb got %h want %h",
        {axi.awsize, axi.wstrb, axi.wdata}, {3'd1, 4'b1100, 32'hCDEF0000});
    end
    tick();
    #1;
    tick();
    #1;
    n_vec++;
    if (data_data_ok !== 1'b1) begin
      n_err++;
      $display("FAIL sh_done got %b want 1", data_data_ok);
    end
    tick();
    axi.awready = 1'b0;
    axi.wready = 1'b0;
    axi.bvalid = 1'b0;
    data_wr = 1'b0;
    #1;
  endtask

  task automatic test_w_before_aw();
    int oks;
    tick();
    data_req = 1'b1;
    data_wr = 1'b1;
    data_size = 2'd2;
    data_addr = 32'h80000010;
    data_wdata = 32'h12345678;
    #1;
    tick();
    data_req = 1'b0;
    axi.wready = 1'b1;
    #1;
    n_vec++;
    if ({axi.awvalid, axi.wvalid, axi.wstrb} !== {2'b11, 4'b1111}) begin
      n_err++;
      $display("FAIL wa_c1 got %b want 111111", {axi.awvalid, axi.wvalid, axi.wstrb});
    end
    tick();
    axi.wready = 1'b0;
    #1;
    n_vec++;
    if ({axi.awvalid, axi.wvalid} !== 2'b10) begin
      n_err++;
      $display("FAIL wa_w_drop got %b want 10", {axi.awvalid, axi.wvalid});
    end
    tick();
    axi.awready = 1'b1;
    #1;
    n_vec++;
    if ({axi.awvalid, axi.wvalid, axi.bready} !== 3'b100) begin
      n_err++;
      $display("FAIL wa_aw_hold got %b want 100", {axi.awvalid, axi.wvalid, axi.bready});
    end
    tick();
    axi.awready = 1'b0;
    axi.bvalid = 1'b1;
    #1;
    n_vec++;
    if ({axi.awvalid, axi.bready, data_data_ok} !== 3'b010) begin
      n_err++;
      $display("FAIL wa_resp got %b want 010", {axi.awvalid, axi.bready, data_data_ok});
    end
    tick();
    axi.bvalid = 1'b0;
    #1;
    n_vec++;
    if ({data_data_ok, axi.bready} !== 2'b10) begin
      n_err++;
      $display("FAIL wa_done got %b want 10", {data_data_ok, axi.bready});
    end
    oks = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      #1;
      if (data_data_ok === 1'b1) oks++;
    end
    n_vec++;
    if (oks !== 0) begin
      n_err++;
      $display("FAIL wa_extra_ok got %0d want 0", oks);
    end
    data_wr = 1'b0;
  endtask

  task automatic test_slow_read();
    int  n_ar;
    int  n_ok;
    int  ok_cyc;
    logic prev_arv;
    tick();
    data_req = 1'b1;
    data_wr = 1'b0;
    data_size = 2'd2;
    data_addr = 32'h80002000;
    axi.arready = 1'b0;
    axi.rvalid = 1'b0;
    axi.rdata = 32'hDEADBEEF;
    #1;
    n_ar = 0;
    n_ok = 0;
    ok_cyc = -1;
    prev_arv = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      tick();
      data_req = 1'b0;
      axi.arready = (c == 6);
      axi.rvalid = (c == 10);
      #1;
      if (axi.arvalid && !prev_arv) n_ar++;
      prev_arv = axi.arvalid;
      if (data_data_ok === 1'b1) begin
        n_ok++;
        ok_cyc = c;
      end
      if (c <= 6) begin
        n_vec++;
        if ({axi.arvalid, axi.araddr} !== {1'b1, 32'h80002000}) begin
          n_err++;
          $display("FAIL sr_ar_c%0d got %h want %h", c,
            {axi.arvalid, axi.araddr}, {1'b1, 32'h80002000});
        end
      end
      if (c == 7) begin
        n_vec++;
        if ({axi.arvalid, axi.rready} !== 2'b01) begin
          n_err++;
          $display("FAIL sr_rd_data got %b want 01", {axi.arvalid, axi.rready});
        end
      end
    end
    n_vec++;
    if (n_ar !== 1) begin
      n_err++;
      $display("FAIL sr_ar_count got %0d want 1", n_ar);
    end
    n_vec++;
    if ({n_ok, ok_cyc} !== {32'd1, 32'd11}) begin
      n_err++;
      $display("FAIL sr_ok got count %0d cyc %0d want count 1 cyc 11", n_ok, ok_cyc);
    end
    n_vec++;
    if (data_rdata !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL sr_rdata got %h want deadbeef", data_rdata);
    end
    axi.arready = 1'b0;
    axi.rvalid = 1'b0;
  endtask

  task automatic test_rst_mid();
    tick();
    inst_req = 1'b1;
    inst_addr = 32'h80003000;
    axi.arready = 1'b1;
    axi.rvalid = 1'b0;
    axi.rdata = 32'h55AA55AA;
    #1;
    tick();
    inst_req = 1'b0;
    #1;
    tick();
    axi.arready = 1'b0;
    #1;
    n_vec++;
    if (axi.rready !== 1'b1) begin
      n_err++;
      $display("FAIL rm_rready got %b want 1", axi.rready);
    end
    rst = 1'b1;
    axi.rvalid = 1'b1;
    tick();
    rst = 1'b0;
    axi.rvalid = 1'b0;
    #1;
    n_vec++;
    if ({axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready, inst_data_ok} !== 6'b0) begin
      n_err++;
      $display("FAIL rm_cleared got %b want 000000",
        {axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready, inst_data_ok});
    end
    tick();
    inst_req = 1'b1;
    #1;
    n_vec++;
    if ({inst_data_ok, inst_addr_ok, inst_rdata} !== {2'b01, 32'h0}) begin
      n_err++;
      $display("FAIL rm_idle got %h want %h",
        {inst_data_ok, inst_addr_ok, inst_rdata}, {2'b01, 32'h0});
    end
    tick();
    inst_req = 1'b0;
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    inst_req = 1'b0;
    inst_addr = '0;
    data_req = 1'b0;
    data_wr = 1'b0;
    data_size = '0;
    data_addr = '0;
    data_wdata = '0;
    axi.arready = 1'b0;
    axi.rid = '0;
    axi.rdata = '0;
    axi.rlast = 1'b1;
    axi.rvalid = 1'b0;
    axi.awready = 1'b0;
    axi.wready = 1'b0;
    axi.bvalid = 1'b0;
    test_reset();
    test_inst_read();
    test_arbitration();
    test_narrow_store();
    test_w_before_aw();
    test_slow_read();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
